// File: rtl/uart_cmd_frame_decoder.sv
// Assembles header/command/checksum frames from the UART byte stream, strobes
// validated commands and answers every completed frame with ACK or NAK.
module uart_cmd_frame_decoder #(
    parameter logic [7:0]  HEADER      = 8'hA5,
    parameter int unsigned TIMEOUT_CYC = 5_000_000,
    parameter logic [7:0]  ACK_OK      = 8'h06,
    parameter logic [7:0]  ACK_ERR     = 8'h15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] I_rx_data,
    input  logic       I_rx_valid,
    input  logic       I_tx_ready,
    output logic [7:0] O_tx_data,
    output logic       O_tx_valid,
    output logic       O_command_flag,
    output logic [3:0] O_ctrl_command,
    output logic [3:0] O_value_command,
    output logic [7:0] O_frame_err_cnt
);

    localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {IDLE, GET_CMD, GET_CHK, ISSUE, ACK} state_t;

    state_t          r_state, w_state;
    logic [TW-1:0]   r_timer, w_timer;
    logic [7:0]      r_cmd, w_cmd;
    logic [7:0]      r_tx_data, w_tx_data;
    logic            r_tx_valid, w_tx_valid;
    logic            r_flag, w_flag;
    logic [3:0]      r_ctrl, w_ctrl;
    logic [3:0]      r_value, w_value;
    logic [7:0]      r_err_cnt, w_err_cnt;
    logic            w_err_inc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_timer    <= '0;
            r_cmd      <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_flag     <= 1'b0;
            r_ctrl     <= '0;
            r_value    <= '0;
            r_err_cnt  <= '0;
        end else begin
            r_state    <= w_state;
            r_timer    <= w_timer;
            r_cmd      <= w_cmd;
            r_tx_data  <= w_tx_data;
            r_tx_valid <= w_tx_valid;
            r_flag     <= w_flag;
            r_ctrl     <= w_ctrl;
            r_value    <= w_value;
            r_err_cnt  <= w_err_cnt;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_timer    = r_timer;
        w_cmd      = r_cmd;
        w_tx_data  = r_tx_data;
        w_tx_valid = r_tx_valid;
        w_flag     = 1'b0;
        w_ctrl     = r_ctrl;
        w_value    = r_value;
        w_err_inc  = 1'b0;

        case (r_state)
            IDLE: begin
                if (I_rx_valid && (I_rx_data == HEADER)) begin
                    w_state = GET_CMD;
                    w_timer = '0;
                end
            end
            GET_CMD: begin
                if (I_rx_valid) begin
                    w_cmd   = I_rx_data;
                    w_state = GET_CHK;
                    w_timer = '0;
                end else if (r_timer == TIMER_LAST) begin
                    w_state   = IDLE;
                    w_timer   = '0;
                    w_err_inc = 1'b1;
                end else begin
                    w_timer = r_timer + 1'b1;
                end
            end
            GET_CHK: begin
                // A byte arriving on the timeout cycle still completes the frame.
                if (I_rx_valid) begin
                    w_timer = '0;
                    if (I_rx_data == (HEADER ^ r_cmd)) begin
                        w_state = ISSUE;
                        w_flag  = 1'b1;
                        w_ctrl  = r_cmd[7:4];
                        w_value = r_cmd[3:0];
                    end else begin
                        w_state    = ACK;
                        w_tx_valid = 1'b1;
                        w_tx_data  = ACK_ERR;
                        w_err_inc  = 1'b1;
                    end
                end else if (r_timer == TIMER_LAST) begin
                    w_state   = IDLE;
                    w_timer   = '0;
                    w_err_inc = 1'b1;
                end else begin
                    w_timer = r_timer + 1'b1;
                end
            end
            ISSUE: begin
                w_state    = ACK;
                w_tx_valid = 1'b1;
                w_tx_data  = ACK_OK;
            end
            ACK: begin
                if (r_tx_valid && I_tx_ready) begin
                    w_state    = IDLE;
                    w_tx_valid = 1'b0;
                end
            end
            default: begin
                w_state    = IDLE;
                w_tx_valid = 1'b0;
            end
        endcase

        w_err_cnt = (w_err_inc && (r_err_cnt != 8'hFF)) ? r_err_cnt + 8'd1 : r_err_cnt;
    end

    assign O_tx_data       = r_tx_data;
    assign O_tx_valid      = r_tx_valid;
    assign O_command_flag  = r_flag;
    assign O_ctrl_command  = r_ctrl;
    assign O_value_command = r_value;
    assign O_frame_err_cnt = r_err_cnt;

endmodule

// File: tb/tb_uart_cmd_frame_decoder.sv
// Bench for uart_cmd_frame_decoder: directed frames plus a random byte stream,
// compared every cycle against a frame-level reference model.
module tb_uart_cmd_frame_decoder;

    localparam int unsigned TO    = 16;
    localparam logic [7:0]  HDR   = 8'hA5;
    localparam logic [7:0]  A_OK  = 8'h06;
    localparam logic [7:0]  A_ERR = 8'h15;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       cmd_flag;
    logic [3:0] ctrl_cmd;
    logic [3:0] value_cmd;
    logic [7:0] err_cnt;

    always #5 clk = ~clk;

    uart_cmd_frame_decoder #(
        .HEADER(HDR), .TIMEOUT_CYC(TO), .ACK_OK(A_OK), .ACK_ERR(A_ERR)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .I_rx_data(rx_data), .I_rx_valid(rx_valid), .I_tx_ready(tx_ready),
        .O_tx_data(tx_data), .O_tx_valid(tx_valid),
        .O_command_flag(cmd_flag), .O_ctrl_command(ctrl_cmd),
        .O_value_command(value_cmd), .O_frame_err_cnt(err_cnt)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: bytes of the frame being collected, idle-cycle count,
    // and the reply/command state seen from outside.
    logic [7:0] m_frame[$];
    int unsigned m_idle;
    bit         m_issue;
    logic       m_flag;
    logic [3:0] m_ctrl, m_val;
    logic       m_txv;
    logic [7:0] m_txd, m_err;

    function automatic logic [7:0] sat_inc(input logic [7:0] x);
        return (x == 8'hFF) ? x : x + 8'd1;
    endfunction

    task automatic model_step();
        logic [7:0] c;
        if (!rst_n) begin
            m_frame.delete();
            m_idle = 0; m_issue = 0; m_flag = 0; m_ctrl = 0; m_val = 0;
            m_txv = 0; m_txd = 0; m_err = 0;
            return;
        end
        m_flag = 0;
        if (m_issue) begin
            m_issue = 0; m_txv = 1; m_txd = A_OK;
        end else if (m_txv) begin
            if (tx_ready) m_txv = 0;
        end else if (m_frame.size() == 0) begin
            if (rx_valid && rx_data == HDR) begin
                m_frame.push_back(rx_data); m_idle = 0;
            end
        end else if (rx_valid) begin
            if (m_frame.size() == 1) begin
                m_frame.push_back(rx_data); m_idle = 0;
            end else begin
                c = m_frame[1];
                if (rx_data == (m_frame[0] ^ c)) begin
                    m_flag = 1; m_ctrl = c[7:4]; m_val = c[3:0]; m_issue = 1;
                end else begin
                    m_txv = 1; m_txd = A_ERR; m_err = sat_inc(m_err);
                end
                m_frame.delete();
            end
        end else begin
            m_idle++;
            if (m_idle == TO) begin
                m_frame.delete(); m_idle = 0; m_err = sat_inc(m_err);
            end
        end
    endtask

    task automatic compare_all();
        check("flag", cmd_flag, m_flag);
        check("ctrl", ctrl_cmd, m_ctrl);
        check("value", value_cmd, m_val);
        check("tx_valid", tx_valid, m_txv);
        if (m_txv) check("tx_data", tx_data, m_txd);
        check("err_cnt", err_cnt, m_err);
    endtask

    task automatic cyc(input logic v, input logic [7:0] d);
        rx_valid = v;
        rx_data  = d;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic send(input logic [7:0] d);
        cyc(1'b1, d);
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) cyc(1'b0, 8'h00);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        cyc(1'b0, 8'h00);
        rst_n = 1'b1;
    endtask

    logic [7:0] q[$];
    logic [7:0] c;

    initial begin
        rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
        @(negedge clk);
        idle(2);
        check("rst_tx_data", tx_data, 8'h00);
        rst_n = 1'b1;

        // good frame
        send(8'hA5); send(8'h13); send(8'hB6); idle(4);
        // bad checksum
        send(8'hA5); send(8'h10); send(8'h00); idle(4);
        // timeout then good frame
        send(8'hA5); idle(20);
        send(8'hA5); send(8'h01); send(8'hA4); idle(4);
        // byte on the timeout cycle wins
        send(8'hA5); idle(TO - 1); send(8'h22); idle(TO - 1); send(8'h87); idle(4);
        // noise and back-pressure, with a header dropped during the stall
        tx_ready = 1'b0;
        send(8'h00); send(8'h3C); send(8'hA5); send(8'h10); send(8'hB5);
        idle(5); send(8'hA5); idle(4);
        tx_ready = 1'b1;
        idle(3);
        // reset mid-frame
        send(8'hA5); send(8'h11); pulse_reset(); send(8'hB4); idle(4);
        // reset during a pending reply
        send(8'hA5); send(8'h42); tx_ready = 1'b0; send(8'hE7); idle(2);
        pulse_reset(); tx_ready = 1'b1; idle(2);
        // saturation
        for (int unsigned i = 0; i < 260; i++) begin
            send(8'hA5); send(8'h10); send(8'h00); idle(2);
        end
        check("err_saturated", err_cnt, 8'd255);
        pulse_reset();

        // random stream
        for (int unsigned n = 0; n < 4000; n++) begin
            tx_ready = ($urandom_range(3) != 0);
            if (q.size() == 0) begin
                c = 8'($urandom_range(255));
                case ($urandom_range(5))
                    0, 1, 2: begin q.push_back(HDR); q.push_back(c); q.push_back(HDR ^ c); end
                    3:       begin q.push_back(HDR); q.push_back(c); q.push_back(HDR ^ c ^ 8'h01); end
                    4:       begin q.push_back(HDR); if ($urandom_range(1) == 1) q.push_back(c); end
                    default: q.push_back(c);
                endcase
            end
            if ($urandom_range(499) == 0) begin
                pulse_reset();
            end else if ($urandom_range(9) == 0) begin
                idle($urandom_range(TO + 4));
            end else if ($urandom_range(1) == 1) begin
                send(q.pop_front());
            end else begin
                cyc(1'b0, 8'($urandom_range(255)));
            end
        end
        tx_ready = 1'b1;
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_cmd_frame_decoder.md
# uart_cmd_frame_decoder

Receives the byte stream from the UART receiver, assembles fixed three-byte command frames (header, command, XOR checksum) and validates them. For each good frame it issues a single-cycle command strobe with the control and value nibbles to the command parser, which drives video-move, split/full-screen and screen-select control. Every completed frame is answered with an ACK or NAK byte to the UART transmitter. Partial frames are discarded on an inter-byte timeout, and frame errors are counted.

## Interface
- HEADER, 8'hA5, frame start byte
- TIMEOUT_CYC, 5_000_000, maximum idle cycles between bytes inside a frame (100 ms at 50 MHz); must be ≥ 2
- ACK_OK, 8'h06, reply byte for a good frame
- ACK_ERR, 8'h15, reply byte for a bad checksum
- clk  in  1  system clock; single clock domain
- rst_n  in  1  synchronous, active-low reset
- I_rx_data  in  8  received byte
- I_rx_valid  in  1  one-cycle strobe; I_rx_data is valid in that cycle
- I_tx_ready  in  1  UART transmitter can accept a byte
- O_tx_data  out  8  reply byte
- O_tx_valid  out  1  reply byte pending
- O_command_flag  out  1  one-cycle strobe for a validated command
- O_ctrl_command  out  4  command byte [7:4], held until the next good frame
- O_value_command  out  4  command byte [3:0], held until the next good frame
- O_frame_err_cnt  out  8  count of bad-checksum and timeout events; saturates at 255

## Operation
- States: IDLE, GET_CMD, GET_CHK, ISSUE, ACK.
- IDLE
  - I_rx_valid with byte == HEADER → GET_CMD; timer cleared.
  - Any other byte is ignored. No error is counted.
- GET_CMD
  - I_rx_valid → latch the byte into cmd_reg; go to GET_CHK; timer cleared.
  - The byte is accepted even if it equals HEADER.
- GET_CHK, on I_rx_valid:
  - byte == HEADER ^ cmd_reg → ISSUE.
  - Otherwise → ACK with ACK_ERR; error count incremented.
- Timer (GET_CMD and GET_CHK only)
  - Increments each cycle without I_rx_valid.
  - On reaching TIMEOUT_CYC-1 without a byte → IDLE; error count incremented; no reply sent.
  - If I_rx_valid and the timeout occur in the same cycle, the byte wins.
- ISSUE (one cycle): O_command_flag = 1 → ACK with ACK_OK.
- ACK
  - O_tx_valid = 1 with O_tx_data stable.
  - The byte transfers on the cycle where O_tx_valid && I_tx_ready; the next state is IDLE.
  - The state holds indefinitely while I_tx_ready = 0.
- Bytes received in ISSUE or ACK are dropped, including a HEADER byte.
- The error counter is 8 bits and does not wrap; 255 + 1 = 255.
- All outputs are registered.

## Timing
- Reset values:
  - State IDLE; timer 0; cmd_reg 0.
  - O_command_flag 0, O_ctrl_command 0, O_value_command 0.
  - O_tx_valid 0, O_tx_data 8'h00, O_frame_err_cnt 0.
- Good frame, checksum sampled at edge N:
  - O_command_flag is high for the cycle N..N+1 only.
  - O_ctrl_command and O_value_command update at the same edge N.
  - O_tx_valid rises at edge N+1.
- Bad checksum sampled at edge N:
  - O_tx_valid = 1 with ACK_ERR from edge N.
  - O_frame_err_cnt increments at edge N.
  - O_command_flag stays 0.
- Timeout: IDLE and the error increment occur at the edge where the timer equals TIMEOUT_CYC-1 and no byte is present.
- Tx handshake: O_tx_valid falls at the edge following the first cycle with I_tx_ready = 1. Minimum one cycle high.
- Reset mid-frame or during ACK aborts immediately:
  - The pending reply is discarded.
  - The held command outputs return to 0.
- Minimum frame-to-frame spacing is 3 bytes + ISSUE + 1 ACK cycle. A header arriving before IDLE is reached is lost.

## Test plan
- Good frame: A5, 13, B6 with I_tx_ready = 1 → O_command_flag one cycle; ctrl = 1, value = 3; O_tx_data = 06 for one cycle; error count 0.
- Bad checksum: A5, 10, 00 → no flag; O_tx_data = 15; O_frame_err_cnt = 1; ctrl and value keep their prior values.
- Timeout with TIMEOUT_CYC = 16: send A5, then idle 20 cycles → IDLE at cycle 15 after A5; error count +1; no tx. Then A5, 01, A4 → flag; ctrl = 0, value = 1.
- Noise and back-pressure:
  - Send 00, 3C, A5, 10, B5 with I_tx_ready held 0 for 10 cycles → flag; ctrl = 1, value = 0.
  - O_tx_valid holds 06 for the full 10 cycles, then transfers.
  - A byte sent during the stall is dropped.
- Reset mid-frame: A5, 11, then rst_n low for one cycle, then B4 → B4 is ignored; no flag, no tx; all outputs 0.
- Saturation: 260 bad-checksum frames → O_frame_err_cnt = 255.
